ysyx_24100006_axi_sram_slave: RTL and testbench

AXI4-subset responder that sits at the memory end of the core's AXI read/write path, behind the IFU/MEMU arbiter. It accepts single-beat and INCR bursts on independent read and write channels. It serves them from an internal word-addressed array with byte-strobe writes and programmable response latency. It is the NPC simulation memory and the target the arbiter is verified against.

---
 rtl/ysyx_24100006_axi_pkg.sv | 16 +
 rtl/ysyx_24100006_axi_sram_mem.sv | 30 +++
 rtl/ysyx_24100006_axi_sram_slave.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_sram_slave.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared AXI response codes, channel FSM encodings and transfer-size limit
// for the simulation SRAM responder.
package ysyx_24100006_axi_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] AXI_SIZE_MAX = 3'd2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic logic [31:0] beat_step(input logic [2:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/ysyx_24100006_axi_sram_mem.sv
// Word array with one asynchronous read port and one byte-strobed
// synchronous write port.
module ysyx_24100006_axi_sram_mem #(
    parameter int DEPTH_WORDS = 65536,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_strb,
    input  logic [31:0]      wr_data
);

    logic [31:0] mem_q [DEPTH_WORDS];

    assign rd_data = mem_q[rd_idx];

    // NOTE: the array has no reset branch (contents are don't-care after power-up),
    // and it is written with <= so a same-edge read still sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ysyx_24100006_axi_sram_slave.sv
// AXI4-subset SRAM responder: independent read and write FSMs with INCR bursts,
// per-beat range checking and programmable response latency.
module ysyx_24100006_axi_sram_slave
    import ysyx_24100006_axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE     = 32'h8000_0000,
    parameter int          DEPTH_WORDS   = 65536,
    parameter int          READ_LATENCY  = 1,
    parameter int          WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS) << 2;
    localparam logic [7:0]  R_LOAD = 8'(READ_LATENCY - 1);
    localparam logic [7:0]  W_LOAD = 8'(WRITE_LATENCY - 1);

    // Addresses below the base wrap to huge offsets, so one compare covers both ends.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr - ADDR_BASE) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - ADDR_BASE) >> 2);
    endfunction

    r_state_e    r_state_q, r_state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [7:0]  ar_len_q, ar_len_d, r_beat_q, r_beat_d, r_cnt_q, r_cnt_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [7:0]  aw_len_q, aw_len_d, w_beat_q, w_beat_d, w_cnt_q, w_cnt_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic        w_err_q, w_err_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0] ar_addr_next, rd_addr, mem_rdata, aw_addr_next;
    logic        rd_ok, w_fire, w_beat_ok, w_is_last, mem_we;

    // The word captured into rdata is the one the next beat will present.
    assign ar_addr_next = ar_addr_q + beat_step(ar_size_q);
    assign rd_addr      = (r_state_q == R_DATA) ? ar_addr_next : ar_addr_q;
    assign rd_ok        = in_range(rd_addr) && (ar_size_q <= AXI_SIZE_MAX);

    assign aw_addr_next = aw_addr_q + beat_step(aw_size_q);
    assign w_fire       = wvalid && wready_q;
    assign w_beat_ok    = in_range(aw_addr_q) && (aw_size_q <= AXI_SIZE_MAX);
    assign w_is_last    = (w_beat_q == aw_len_q);
    assign mem_we       = w_fire && w_beat_ok;

    ysyx_24100006_axi_sram_mem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk     (clk),
        .rd_idx  (word_idx(rd_addr)),
        .rd_data (mem_rdata),
        .we      (mem_we),
        .wr_idx  (word_idx(aw_addr_q)),
        .wr_strb (wstrb),
        .wr_data (wdata)
    );

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        r_state_d = r_state_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_size_d = ar_size_q;
        r_beat_d  = r_beat_q;
        r_cnt_d   = r_cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    ar_addr_d = araddr;
                    ar_len_d  = arlen;
                    ar_size_d = arsize;
                    r_beat_d  = 8'd0;
                    r_cnt_d   = R_LOAD;
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 8'd0) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_ok ? mem_rdata : 32'd0;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = (ar_len_q == 8'd0);
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q - 8'd1;
                end
            end
            R_DATA: begin
                if (rready && rlast_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    rresp_d   = RESP_OKAY;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end else if (rready) begin
                    ar_addr_d = ar_addr_next;
                    r_beat_d  = r_beat_q + 8'd1;
                    rdata_d   = rd_ok ? mem_rdata : 32'd0;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = (r_beat_q + 8'd1 == ar_len_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
            r_beat_q  <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
            ar_size_q <= ar_size_d;
            r_beat_q  <= r_beat_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Errors accumulate across the burst; completion still follows awlen alone.
    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        aw_len_d  = aw_len_q;
        aw_size_d = aw_size_q;
        w_beat_d  = w_beat_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    aw_addr_d = awaddr;
                    aw_len_d  = awlen;
                    aw_size_d = awsize;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    aw_addr_d = aw_addr_next;
                    w_err_d   = w_err_q || !w_beat_ok || (wlast != w_is_last);
                    if (w_is_last) begin
                        wready_d  = 1'b0;
                        w_cnt_d   = W_LOAD;
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (!bvalid_q) begin
                    if (w_cnt_q == 8'd0) begin
                        bvalid_d = 1'b1;
                        bresp_d  = w_err_q ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_cnt_d = w_cnt_q - 8'd1;
                    end
                end else if (bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            aw_size_q <= '0;
            w_beat_q  <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            aw_len_q  <= aw_len_d;
            aw_size_q <= aw_size_d;
            w_beat_q  <= w_beat_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_24100006_axi_sram_slave.sv
// Self-checking bench: directed vector table, burst/reset corner sequences,
// and randomized bursts scored against an associative-array memory model.
module tb_ysyx_24100006_axi_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 65536;
    localparam int          RL    = 1;
    localparam int          WL    = 1;
    localparam logic [31:0] TOP   = BASE + 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0, rlast;
    logic [31:0] araddr = '0, rdata;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = '0, awsize = '0;
    logic [1:0]  rresp, bresp;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
    logic        bvalid, bready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;

    always #5 clk = ~clk;

    ysyx_24100006_axi_sram_slave #(
        .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];
    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic        rq_last[$];

    // Reference memory: word index -> contents, only for words the bench has written.
    logic [31:0] model_mem [int unsigned];

    function automatic bit m_ok(input logic [31:0] a, input logic [2:0] size);
        return (size <= 3'd2) && (a >= BASE) && (a < TOP);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int b, input logic [2:0] size);
        return a + 32'(b) * (32'd1 << size);
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [2:0] size, input int bad_last);
        bit          err;
        logic [31:0] a, w;
        int unsigned idx;
        err = (bad_last >= 0) && (bad_last <= len);
        for (int b = 0; b <= len; b++) begin
            a = beat_addr(addr, b, size);
            if (!m_ok(a, size)) begin
                err = 1'b1;
            end else begin
                idx = (a - BASE) / 4;
                w = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
                for (int i = 0; i < 4; i++)
                    if (wq_strb[b][i]) w[8*i +: 8] = wq_data[b][8*i +: 8];
                model_mem[idx] = w;
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input int bad_last, output logic [1:0] resp);
        int g, lat;
        awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
        g = 0;
        while (!awready && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wq_data[b]; wstrb = wq_strb[b];
            wlast = (b == int'(len)) != (b == bad_last);
            wvalid = 1'b1;
            g = 0;
            while (!wready && g < 50) begin @(posedge clk); #1; g++; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bvalid && lat < 50);
        check("b_latency", lat, WL);
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("b_dropped", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input bit stall);
        int g, lat;
        logic [31:0] d0;
        logic [2:0]  c0;
        rq_data.delete(); rq_resp.delete(); rq_last.delete();
        araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
        g = 0;
        while (!arready && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rvalid && lat < 50);
        check("r_latency", lat, RL);
        for (int b = 0; b <= int'(len); b++) begin
            if (stall && b > 0) begin
                rready = 1'b0;
                d0 = rdata; c0 = {rlast, rresp};
                @(posedge clk); #1;
                check("r_hold_data", rdata, d0);
                check("r_hold_ctrl", {rvalid, rlast, rresp}, {1'b1, c0});
            end
            rready = 1'b1;
            g = 0;
            while (!rvalid && g < 50) begin @(posedge clk); #1; g++; end
            rq_data.push_back(rdata); rq_resp.push_back(rresp); rq_last.push_back(rlast);
            @(posedge clk); #1;
        end
        rready = 1'b0;
        check("r_idle_after_last", rvalid, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input int bad_last, input string tag);
        logic [1:0] resp, exp;
        exp = model_write(addr, len, size, bad_last);
        axi_write(addr, 8'(len), size, bad_last, resp);
        check({tag, "_bresp"}, resp, exp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input bit stall, input string tag);
        logic [31:0] a;
        int unsigned idx;
        axi_read(addr, 8'(len), size, stall);
        for (int b = 0; b <= len; b++) begin
            a = beat_addr(addr, b, size);
            check({tag, "_rlast"}, rq_last[b], b == len);
            if (m_ok(a, size)) begin
                check({tag, "_rresp"}, rq_resp[b], 2'b00);
                idx = (a - BASE) / 4;
                if (model_mem.exists(idx)) check({tag, "_rdata"}, rq_data[b], model_mem[idx]);
            end else begin
                check({tag, "_rresp_err"}, rq_resp[b], 2'b10);
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_resp;
        bit          chk_data;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wd,
                                logic [3:0] ws, logic [1:0] er, bit cd, logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.addr = addr; v.size = size; v.wdata = wd; v.wstrb = ws;
        v.exp_resp = er; v.chk_data = cd; v.exp_data = ed;
        return v;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [1:0]  resp;
        logic [31:0] a;
        int          len, bad;
        logic [2:0]  size;

        vecs.push_back(mk(1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0));
        vecs.push_back(mk(0, BASE + 32'h10, 3'd2, 0, 0, 2'b00, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, BASE + 32'h20, 3'd2, 32'h1122_3344, 4'hF, 2'b00, 0, 0));
        vecs.push_back(mk(1, BASE + 32'h22, 3'd0, 32'h00AB_0000, 4'b0100, 2'b00, 0, 0));
        vecs.push_back(mk(0, BASE + 32'h20, 3'd2, 0, 0, 2'b00, 1, 32'h11AB_3344));
        vecs.push_back(mk(1, BASE + 32'h24, 3'd2, 32'h5566_7788, 4'hF, 2'b00, 0, 0));
        vecs.push_back(mk(1, BASE + 32'h26, 3'd1, 32'hCAFE_0000, 4'b1100, 2'b00, 0, 0));
        vecs.push_back(mk(0, BASE + 32'h24, 3'd2, 0, 0, 2'b00, 1, 32'hCAFE_7788));
        vecs.push_back(mk(1, TOP - 32'h4, 3'd2, 32'h0A0B_0C0D, 4'hF, 2'b00, 0, 0));
        vecs.push_back(mk(1, 32'h7FFF_FFFC, 3'd2, 32'h1234_5678, 4'hF, 2'b10, 0, 0));
        vecs.push_back(mk(0, 32'h7FFF_FFFC, 3'd2, 0, 0, 2'b10, 0, 0));
        vecs.push_back(mk(0, TOP - 32'h4, 3'd2, 0, 0, 2'b00, 1, 32'h0A0B_0C0D));
        vecs.push_back(mk(1, TOP, 3'd2, 32'h9999_9999, 4'hF, 2'b10, 0, 0));
        vecs.push_back(mk(0, TOP, 3'd2, 0, 0, 2'b10, 0, 0));
        vecs.push_back(mk(1, BASE + 32'h10, 3'd3, 32'hAAAA_AAAA, 4'hF, 2'b10, 0, 0));
        vecs.push_back(mk(0, BASE + 32'h10, 3'd2, 0, 0, 2'b00, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, BASE + 32'h10, 3'd3, 0, 0, 2'b10, 0, 0));

        // Reset state and release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {arready, awready, rvalid, rlast, wready, bvalid, rresp, bresp}, 10'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b1;
        check("rst_arready_pre", {arready, awready}, 2'b00);
        @(posedge clk); #1;
        check("rst_ready_post", {arready, awready}, 2'b11);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                wq_data.delete(); wq_strb.delete();
                wq_data.push_back(vecs[i].wdata); wq_strb.push_back(vecs[i].wstrb);
                axi_write(vecs[i].addr, 8'd0, vecs[i].size, -1, resp);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, 8'd0, vecs[i].size, 1'b0);
                check($sformatf("vec%0d_rresp", i), rq_resp[0], vecs[i].exp_resp);
                check($sformatf("vec%0d_rlast", i), rq_last[0], 1'b1);
                if (vecs[i].chk_data)
                    check($sformatf("vec%0d_rdata", i), rq_data[0], vecs[i].exp_data);
            end
        end

        // 4-beat burst, read back with rready toggling.
        wq_data.delete(); wq_strb.delete();
        for (int b = 0; b < 4; b++) begin
            wq_data.push_back(32'hA000_0000 + 32'(b * 4)); wq_strb.push_back(4'hF);
        end
        axi_write(BASE, 8'd3, 3'd2, -1, resp);
        check("burst_bresp", resp, 2'b00);
        axi_read(BASE, 8'd3, 3'd2, 1'b1);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("burst_rdata%0d", b), rq_data[b], 32'hA000_0000 + 32'(b * 4));
            check($sformatf("burst_rlast%0d", b), rq_last[b], b == 3);
            check($sformatf("burst_rresp%0d", b), rq_resp[b], 2'b00);
        end

        // Early wlast: both beats land, response is SLVERR.
        wq_data.delete(); wq_strb.delete();
        wq_data.push_back(32'h1111_1111); wq_strb.push_back(4'hF);
        wq_data.push_back(32'h2222_2222); wq_strb.push_back(4'hF);
        axi_write(BASE + 32'h40, 8'd1, 3'd2, 0, resp);
        check("wlast_bresp", resp, 2'b10);
        axi_read(BASE + 32'h40, 8'd1, 3'd2, 1'b0);
        check("wlast_beat0", rq_data[0], 32'h1111_1111);
        check("wlast_beat1", rq_data[1], 32'h2222_2222);

        // Randomized traffic over two prefilled windows, one straddling the top of memory.
        for (int k = 0; k < 4; k++) begin
            wq_data.delete(); wq_strb.delete();
            for (int b = 0; b < 16; b++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
            do_write(BASE + 32'h100 + 32'(k * 64), 15, 3'd2, -1, "prefill");
        end
        wq_data.delete(); wq_strb.delete();
        for (int b = 0; b < 16; b++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        do_write(TOP - 32'd64, 15, 3'd2, -1, "prefill_top");

        for (int n = 0; n < 60; n++) begin
            len  = $urandom_range(0, 3);
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) a = TOP - 32'd16 + 32'($urandom_range(0, 23));
            else a = BASE + 32'h100 + 32'($urandom_range(0, 47) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                wq_data.delete(); wq_strb.delete();
                for (int b = 0; b <= len; b++) begin
                    wq_data.push_back($urandom); wq_strb.push_back(4'($urandom));
                end
                bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
                do_write(a, len, size, bad, "rnd_w");
            end else begin
                do_read(a, len, size, 1'($urandom_range(0, 1)), "rnd_r");
            end
        end

        // Reset asserted while a burst is presenting data.
        araddr = BASE; arlen = 8'd3; arsize = 3'd2; arvalid = 1'b1;
        for (int g = 0; g < 50 && !arready; g++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int g = 0; g < 50 && !rvalid; g++) begin @(posedge clk); #1; end
        check("rst_mid_rvalid_pre", rvalid, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_ctrl", {rvalid, rlast, arready, rresp}, 5'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst_mid_arready_pre", arready, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_arready_post", arready, 1'b1);
        axi_read(BASE + 32'h4, 8'd0, 3'd2, 1'b0);
        check("rst_mid_fresh_rdata", rq_data[0], 32'hA000_0004);
        check("rst_mid_fresh_rresp", rq_resp[0], 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
